// File: rtl/c1541_track_loader.sv
// Track-buffer manager for the 1541 GCR stage: writes back dirty sectors of the old track and
// loads every sector of the new track into port B of the dual-port track buffer.
module c1541_track_loader #(
  parameter int unsigned NUM_TRACKS = 35
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic [5:0]  track,
  input  logic        img_mounted,
  input  logic        img_present,
  input  logic        wp,
  input  logic [4:0]  gcr_sector,
  input  logic        gcr_we,
  output logic        ram_ready,
  output logic        busy,
  output logic [9:0]  sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [12:0] buf_addr,
  output logic        buf_we,
  output logic [7:0]  buf_din,
  input  logic [7:0]  buf_dout
);

  typedef enum logic [2:0] {
    StIdle, StFlushReq, StFlushXfer, StLoadReq, StLoadXfer, StReady
  } state_e;

  state_e      state_q, state_d;
  logic [20:0] dirty_q, dirty_d;
  logic [5:0]  loaded_q, loaded_d;
  logic [5:0]  target_q, target_d;
  logic [4:0]  sector_q, sector_d;
  logic [9:0]  lba_q, lba_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic        ack_q, mount_q, mount_d;
  logic        ack_fall, track_valid;
  logic [4:0]  first_dirty;

  // The host samples buf_dout directly; nothing here consumes it.
  logic unused_buf_dout;
  assign unused_buf_dout = ^buf_dout;

  function automatic logic [4:0] spt(input logic [5:0] t);
    if (t <= 6'd17)      return 5'd21;
    else if (t <= 6'd24) return 5'd19;
    else if (t <= 6'd30) return 5'd18;
    else                 return 5'd17;
  endfunction

  function automatic logic [9:0] base(input logic [5:0] t);
    logic [9:0] tt;
    tt = {4'd0, t};
    if (t == 6'd0)       return 10'd0;
    else if (t <= 6'd17) return (tt - 10'd1) * 10'd21;
    else if (t <= 6'd24) return 10'd357 + (tt - 10'd18) * 10'd19;
    else if (t <= 6'd30) return 10'd490 + (tt - 10'd25) * 10'd18;
    else                 return 10'd598 + (tt - 10'd31) * 10'd17;
  endfunction

  function automatic logic [4:0] lowest(input logic [20:0] m);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 20; i >= 0; i--) begin
      if (m[i]) r = 5'(i);
    end
    return r;
  endfunction

  assign ack_fall    = ack_q & ~sd_ack;
  assign track_valid = (track != 6'd0) && (32'(track) <= NUM_TRACKS);

  always_comb begin
    state_d     = state_q;
    dirty_d     = dirty_q;
    loaded_d    = loaded_q;
    target_d    = target_q;
    sector_d    = sector_q;
    lba_d       = lba_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    mount_d     = mount_q | img_mounted;
    first_dirty = 5'd0;

    unique case (state_q)
      StIdle: begin
        mount_d = 1'b0;
        if (img_present && track_valid && track != loaded_q && !img_mounted) begin
          if (dirty_q != '0) begin
            first_dirty = lowest(dirty_q);
            state_d     = StFlushReq;
            sector_d    = first_dirty;
            lba_d       = base(loaded_q) + {5'd0, first_dirty};
          end else begin
            state_d  = StLoadReq;
            target_d = track;
            sector_d = 5'd0;
            lba_d    = base(track);
            loaded_d = '0;
          end
        end
      end
      StFlushReq: begin
        wr_d = 1'b1;
        if (sd_ack) state_d = StFlushXfer;
      end
      StFlushXfer: begin
        if (ack_fall) begin
          wr_d              = 1'b0;
          dirty_d[sector_q] = 1'b0;
          if (mount_d) begin
            state_d = StIdle;
            mount_d = 1'b0;
          end else if (dirty_d != '0) begin
            first_dirty = lowest(dirty_d);
            state_d     = StFlushReq;
            sector_d    = first_dirty;
            lba_d       = base(loaded_q) + {5'd0, first_dirty};
          end else if (track_valid && img_present) begin
            state_d  = StLoadReq;
            target_d = track;
            sector_d = 5'd0;
            lba_d    = base(track);
            loaded_d = '0;
          end else begin
            state_d  = StIdle;
            loaded_d = '0;
          end
        end
      end
      StLoadReq: begin
        rd_d = 1'b1;
        if (sd_ack) state_d = StLoadXfer;
      end
      StLoadXfer: begin
        if (ack_fall) begin
          rd_d = 1'b0;
          if (mount_d) begin
            state_d = StIdle;
            mount_d = 1'b0;
          end else if (sector_q == spt(target_q) - 5'd1) begin
            loaded_d = target_q;
            state_d  = (track == target_q) ? StReady : StIdle;
          end else if (track != target_q) begin
            // Abandon the rest of this track; IDLE restarts the load for the new one.
            state_d = StIdle;
          end else begin
            state_d  = StLoadReq;
            sector_d = sector_q + 5'd1;
            lba_d    = lba_q + 10'd1;
          end
        end
      end
      StReady: begin
        mount_d = 1'b0;
        if (gcr_we && !wp && gcr_sector < spt(loaded_q)) dirty_d[gcr_sector] = 1'b1;
        if (track != loaded_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A new image invalidates the buffer without write-back.
    if (img_mounted) begin
      dirty_d  = '0;
      loaded_d = '0;
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q  <= StIdle;
      dirty_q  <= '0;
      loaded_q <= '0;
      target_q <= '0;
      sector_q <= '0;
      lba_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ack_q    <= 1'b0;
      mount_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dirty_q  <= dirty_d;
      loaded_q <= loaded_d;
      target_q <= target_d;
      sector_q <= sector_d;
      lba_q    <= lba_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ack_q    <= sd_ack;
      mount_q  <= mount_d;
    end
  end

  assign sd_rd     = rd_q;
  assign sd_wr     = wr_q;
  assign sd_lba    = lba_q;
  assign busy      = (state_q != StIdle) && (state_q != StReady);
  assign ram_ready = (state_q == StReady) && (loaded_q == track) && img_present;
  assign buf_addr  = {sector_q, sd_buff_addr};
  assign buf_din   = sd_buff_dout;
  assign buf_we    = sd_buff_wr & sd_ack & (state_q == StLoadXfer);

endmodule

// File: tb/tb_c1541_track_loader.sv
// Directed bench: expected host requests are queued per step and checked as the DUT issues them.
module tb_c1541_track_loader;

  logic        clk32 = 1'b0;
  logic        reset, img_mounted, img_present, wp, gcr_we;
  logic [5:0]  track;
  logic [4:0]  gcr_sector;
  logic        ram_ready, busy, sd_rd, sd_wr, sd_ack, sd_buff_wr, buf_we;
  logic [9:0]  sd_lba;
  logic [7:0]  sd_buff_addr, sd_buff_dout, buf_din, buf_dout;
  logic [12:0] buf_addr;

  always #5 clk32 = ~clk32;

  c1541_track_loader #(.NUM_TRACKS(35)) dut (
    .clk32(clk32), .reset(reset), .track(track), .img_mounted(img_mounted),
    .img_present(img_present), .wp(wp), .gcr_sector(gcr_sector), .gcr_we(gcr_we),
    .ram_ready(ram_ready), .busy(busy), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .buf_addr(buf_addr), .buf_we(buf_we), .buf_din(buf_din),
    .buf_dout(buf_dout)
  );

  typedef struct {
    bit wr;
    int lba;
    int sec;
  } req_t;

  req_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   host_busy = 0;
  int   cur_lba = -1;

  assign buf_dout = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_range(input bit wr, input int lba0, input int sec0, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{wr, lba0 + i, sec0 + i});
  endtask

  task automatic step();
    @(posedge clk32);
    #1;
  endtask

  task automatic gcr_write(input logic [4:0] s);
    step();
    gcr_sector = s;
    gcr_we     = 1'b1;
    step();
    gcr_we     = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (n < 30000 && !(ram_ready === 1'b1 && exp_q.size() == 0 && !host_busy)) begin
      @(negedge clk32);
      n++;
    end
    check({tag, "_ram_ready"}, 32'(ram_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Host block-I/O model: answers each request and checks it against the queue.
  initial begin
    req_t       e;
    bit         is_wr;
    int         bad, n;
    logic [7:0] d;
    sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
    forever begin
      @(negedge clk32);
      if (sd_rd === 1'b1 || sd_wr === 1'b1) begin
        host_busy = 1;
        is_wr     = sd_wr;
        cur_lba   = int'(sd_lba);
        check("rd_wr_exclusive", 32'(sd_rd & sd_wr), 32'd0);
        check("ready_low_during_xfer", 32'(ram_ready), 32'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL unexpected_req: got lba %0d wr %0d expected no request", cur_lba, is_wr);
          e = '{is_wr, cur_lba, 0};
        end else begin
          e = exp_q.pop_front();
        end
        check("req_is_write", 32'(is_wr), 32'(e.wr));
        check("req_lba", 32'(cur_lba), 32'(e.lba));
        repeat (2) @(posedge clk32);
        #1 sd_ack = 1'b1;
        bad = 0;
        for (int b = 0; b < 256; b++) begin
          step();
          d            = 8'(cur_lba) ^ 8'(b);
          sd_buff_addr = 8'(b);
          sd_buff_dout = d;
          sd_buff_wr   = !is_wr;
          @(negedge clk32);
          if (buf_we !== !is_wr || buf_addr !== {5'(e.sec), 8'(b)} || (!is_wr && buf_din !== d))
            bad++;
        end
        step();
        sd_buff_wr = 1'b0;
        check("xfer_bytes_bad", 32'(bad), 32'd0);
        repeat (2) @(posedge clk32);
        #1 sd_ack = 1'b0;
        n = 0;
        while ((sd_rd === 1'b1 || sd_wr === 1'b1) && n < 8) begin
          @(negedge clk32);
          n++;
        end
        check("req_dropped", 32'(sd_rd | sd_wr), 32'd0);
        host_busy = 0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; img_mounted = 1'b0; img_present = 1'b0; wp = 1'b0;
    gcr_we = 1'b0; gcr_sector = '0; track = 6'd1;
    repeat (3) step();
    reset = 1'b0;
    step();
    @(negedge clk32);
    check("rst_ram_ready", 32'(ram_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sd_rd", 32'(sd_rd), 32'd0);
    check("rst_sd_wr", 32'(sd_wr), 32'd0);
    check("rst_sd_lba", 32'(sd_lba), 32'd0);
    check("rst_buf_we", 32'(buf_we), 32'd0);
    check("rst_buf_addr", 32'(buf_addr), 32'd0);

    // Initial load of track 1, then zone boundaries.
    push_range(0, 0, 0, 21);
    step();
    img_present = 1'b1;
    wait_ready("t1_load");
    push_range(0, 357, 0, 19);
    step();
    track = 6'd18;
    wait_ready("t18_load");
    push_range(0, 666, 0, 17);
    step();
    track = 6'd35;
    wait_ready("t35_load");

    // Dirty sectors 3 and 7 on track 1 are written back before track 2 loads.
    push_range(0, 0, 0, 21);
    step();
    track = 6'd1;
    wait_ready("t1_reload");
    gcr_write(5'd3);
    gcr_write(5'd7);
    push_range(1, 3, 3, 1);
    push_range(1, 7, 7, 1);
    push_range(0, 21, 0, 21);
    step();
    track = 6'd2;
    wait_ready("flush_then_t2");

    // Write-protected image: GCR writes leave nothing dirty.
    wp = 1'b1;
    gcr_write(5'd3);
    gcr_write(5'd7);
    push_range(0, 0, 0, 21);
    step();
    track = 6'd1;
    wait_ready("wp_no_flush");
    wp = 1'b0;

    // Track change while the LBA 25 read is in flight.
    push_range(0, 21, 0, 5);
    step();
    track = 6'd2;
    n = 0;
    while (n < 20000 && !(cur_lba == 25 && sd_ack === 1'b1)) begin
      step();
      n++;
    end
    check("lba25_in_flight", 32'(cur_lba), 32'd25);
    push_range(0, 42, 0, 21);
    track = 6'd3;
    wait_ready("midload_t3");

    // New image discards the dirty mask and reloads the current track.
    gcr_write(5'd5);
    push_range(0, 42, 0, 21);
    step();
    img_mounted = 1'b1;
    step();
    img_mounted = 1'b0;
    wait_ready("mount_reload");

    // Invalid track: no requests, buffer not ready.
    step();
    track = 6'd0;
    repeat (300) step();
    @(negedge clk32);
    check("t0_ram_ready", 32'(ram_ready), 32'd0);
    check("t0_busy", 32'(busy), 32'd0);
    check("t0_sd_rd", 32'(sd_rd), 32'd0);
    check("t0_pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
